// File: rtl/mant_mult_pkg.sv
// -----------------------------------------------------------------------------
// mant_mult_pkg
// Shared definitions for the time-multiplexed mantissa multiplier.
// Contents:
//   - operand / chunk widths and number of 7x7 units
//   - op encodings (OP_28, OP_14, OP_7, OP_RSVD)
//   - sequencer state enum (IDLE, CALC, DONE)
//   - beats-per-mode constants and a helper giving the last beat index
// -----------------------------------------------------------------------------
package mant_mult_pkg;

    localparam int MW        = 28;
    localparam int CW        = 7;
    localparam int NUM_UNITS = 4;

    localparam int BEATS_28 = 4;
    localparam int BEATS_14 = 2;
    localparam int BEATS_7  = 1;

    typedef enum logic [1:0] {
        OP_28   = 2'b00,
        OP_14   = 2'b01,
        OP_7    = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index of the final beat for a given mode; reserved behaves as 28x28.
    function automatic logic [1:0] last_beat_idx(input op_t op);
        case (op)
            OP_14:   return 2'(BEATS_14 - 1);
            OP_7:    return 2'(BEATS_7 - 1);
            default: return 2'(BEATS_28 - 1);
        endcase
    endfunction

endpackage

// File: rtl/UnsignedMultiplier7x7.sv
// -----------------------------------------------------------------------------
// UnsignedMultiplier7x7
// Combinational 7x7 unsigned multiplier, one of the four shared units.
// Ports:
//   a, b    : 7-bit unsigned operands
//   product : 14-bit unsigned product
// -----------------------------------------------------------------------------
module UnsignedMultiplier7x7 (
    input  logic [6:0]  a,
    input  logic [6:0]  b,
    output logic [13:0] product
);

    assign product = a * b;

endmodule

// File: rtl/mant_mult_beat_mux.sv
// -----------------------------------------------------------------------------
// mant_mult_beat_mux
// Selects the chunk operands for each of the four 7x7 units and the bit
// offset at which each product lands in the 56-bit accumulator, as a
// function of mode and beat. Fully combinational.
// Ports:
//   active : high only while the sequencer is calculating; otherwise all
//            unit operands are forced to zero so the units stay quiet
//   op     : registered mode (reserved already folded into OP_28)
//   beat   : registered beat index
//   a, b   : registered 28-bit operands
//   mul_a, mul_b : per-unit 7-bit operands
//   shift  : per-unit left shift into the accumulator (0..42)
// -----------------------------------------------------------------------------
module mant_mult_beat_mux
    import mant_mult_pkg::*;
(
    input  logic                            active,
    input  op_t                             op,
    input  logic [1:0]                      beat,
    input  logic [MW-1:0]                   a,
    input  logic [MW-1:0]                   b,
    output logic [NUM_UNITS-1:0][CW-1:0]    mul_a,
    output logic [NUM_UNITS-1:0][CW-1:0]    mul_b,
    output logic [NUM_UNITS-1:0][5:0]       shift
);

    // Every mode is expressed as four shifted partial products summed into
    // one accumulator. In 14x14 mode a lane's full product fits in 28 bits
    // and each lane is produced in a single beat, so no carry can cross
    // into the neighbouring lane.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        shift = '0;
        if (active) begin
            case (op)
                OP_14: begin
                    mul_a[0] = a[2*CW*int'(beat[0]) +: CW];
                    mul_b[0] = b[2*CW*int'(beat[0]) +: CW];
                    shift[0] = 6'(MW*int'(beat[0]));
                    mul_a[1] = a[2*CW*int'(beat[0]) +: CW];
                    mul_b[1] = b[2*CW*int'(beat[0]) + CW +: CW];
                    shift[1] = 6'(MW*int'(beat[0]) + CW);
                    mul_a[2] = a[2*CW*int'(beat[0]) + CW +: CW];
                    mul_b[2] = b[2*CW*int'(beat[0]) +: CW];
                    shift[2] = 6'(MW*int'(beat[0]) + CW);
                    mul_a[3] = a[2*CW*int'(beat[0]) + CW +: CW];
                    mul_b[3] = b[2*CW*int'(beat[0]) + CW +: CW];
                    shift[3] = 6'(MW*int'(beat[0]) + 2*CW);
                end
                OP_7: begin
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        mul_a[i] = a[CW*i +: CW];
                        mul_b[i] = b[CW*i +: CW];
                        shift[i] = 6'(2*CW*i);
                    end
                end
                default: begin
                    // Beat k takes A chunk k against every B chunk j.
                    for (int j = 0; j < NUM_UNITS; j++) begin
                        mul_a[j] = a[CW*int'(beat) +: CW];
                        mul_b[j] = b[CW*j +: CW];
                        shift[j] = 6'(CW*(int'(beat) + j));
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mantissa_mult_sequencer.sv
// -----------------------------------------------------------------------------
// mantissa_mult_sequencer
// Time-multiplexed mantissa multiplier: four shared 7x7 units are sequenced
// over 4, 2 or 1 beats to form one 28x28, two 14x14 or four 7x7 products.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_a, in_b, in_op    : operands and mode, sampled only on acceptance
//   out_valid / out_ready: product handshake (valid only in DONE)
//   out_prod             : 56-bit product or packed lane products
//   busy                 : high while calculating or holding a result
// -----------------------------------------------------------------------------
module mantissa_mult_sequencer
    import mant_mult_pkg::*;
#(
    parameter int MW = 28,
    parameter int CW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-1:0]   in_a,
    input  logic [MW-1:0]   in_b,
    input  logic [1:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*MW-1:0] out_prod,
    output logic            busy
);

    state_t                            state;
    op_t                               op_reg;
    logic [MW-1:0]                     a_reg;
    logic [MW-1:0]                     b_reg;
    logic [1:0]                        beat;
    logic [2*MW-1:0]                   acc;

    logic [NUM_UNITS-1:0][CW-1:0]      mul_a;
    logic [NUM_UNITS-1:0][CW-1:0]      mul_b;
    logic [NUM_UNITS-1:0][5:0]         shift;
    logic [NUM_UNITS-1:0][2*CW-1:0]    prod;
    logic [2*MW-1:0]                   beat_sum;

    // Operand steering only looks at registered state, never at the inputs.
    mant_mult_beat_mux u_beat_mux (
        .active (state == CALC),
        .op     (op_reg),
        .beat   (beat),
        .a      (a_reg),
        .b      (b_reg),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .shift  (shift)
    );

    for (genvar j = 0; j < NUM_UNITS; j++) begin : g_mult
        UnsignedMultiplier7x7 u_mult (
            .a       (mul_a[j]),
            .b       (mul_b[j]),
            .product (prod[j])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            beat_sum = beat_sum + ((2*MW)'(prod[j]) << shift[j]);
        end
    end

    // The accumulator doubles as the output register, so the product is
    // naturally held stable in DONE until the consumer takes it.
    assign out_prod = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_reg    <= OP_28;
            a_reg     <= '0;
            b_reg     <= '0;
            beat      <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        // Reserved mode is folded into 28x28 at capture.
                        op_reg   <= (op_t'(in_op) == OP_RSVD) ? OP_28 : op_t'(in_op);
                        acc      <= '0;
                        beat     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc + beat_sum;
                    if (beat == last_beat_idx(op_reg)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mantissa_mult_sequencer.md
Name: mantissa_mult_sequencer

Overview:
- Time-multiplexed controller for the mantissa multiplier datapath. It sequences a bank of four UnsignedMultiplier7x7 units over 1, 2 or 4 beats to produce one 28x28, two 14x14 or four 7x7 unsigned products.
- It replaces the fully parallel 16-unit array in area-constrained FMAU configurations.
- It sits between operand decode and the FMA adder stage, with valid/ready handshakes on both sides.

Parameters:
- MW, 28, mantissa operand width; only 28 is supported.
- CW, 7, chunk width of each sub-multiplier; fixed at MW/4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  sequencer can accept operands
- in_a  input  28  operand A
- in_b  input  28  operand B
- in_op  input  2  mode: 00=1x28x28, 01=2x14x14, 10=4x7x7, 11=reserved (treated as 00)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_prod  output  56  product or packed lane products
- busy  output  1  high in CALC or DONE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_prod=0, beat counter=0. The operand latches and accumulator clear to 0.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch in_a, in_b and in_op; clear the accumulator; set beat=0; go to CALC.
- CALC:
  - One beat per cycle. Each beat drives four 7x7 products into the accumulator.
  - On the last beat, go to DONE.
  - Beat count: mode 00 needs 4 beats, mode 01 needs 2, mode 10 needs 1.
- Mode 00, beat k (0..3):
  - Compute A[7k+6:7k]*B[7j+6:7j] for j=0..3.
  - Add each product shifted left by 7(k+j) into the 56-bit accumulator.
  - No overflow is possible.
- Mode 01, beat L (0..1), lane L:
  - Compute the 4 chunk products of A[14L+13:14L] and B[14L+13:14L], chunk shifts 0/7/7/14.
  - Sum them into out_prod[28L+27:28L].
  - Other lanes are untouched, with no carry across the lane boundary.
- Mode 10, single beat:
  - Lane i = A[7i+6:7i]*B[7i+6:7i] goes to out_prod[14i+13:14i].
  - No cross-lane terms.
- Latency: accept edge E0; the last beat completes at edge E(n) with n=beats; out_valid rises after E(n).
  - Mode 00: 4 cycles.
  - Mode 01: 2 cycles.
  - Mode 10: 1 cycle.
- DONE:
  - out_valid=1, and out_prod is held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE with out_valid=0 next cycle.
- in_ready is high only in IDLE. in_valid in CALC/DONE is ignored and does not latch anything.
- Operands and mode are sampled only at acceptance. Input changes mid-operation have no effect.
- Reset asserted mid-operation aborts immediately:
  - All state returns to reset values.
  - No partial product is emitted after release.
- Sub-multiplier operand muxing is driven from registered state only; the unit does not compute in IDLE.

Decomposition:
- Shared package mant_mult_pkg holds:
  - op encodings OP_28, OP_14, OP_7 and OP_RSVD;
  - state enum IDLE/CALC/DONE;
  - constants MW=28, CW=7, NUM_UNITS=4;
  - beats-per-mode constants.
- Sub-module: instantiate the existing UnsignedMultiplier7x7 four times.
- Natural sub-module: mant_mult_beat_mux, which selects chunk operands and shift amounts per mode and beat (combinational). The FSM and accumulator stay in the top level.

Test Plan:
1. op=00, A=B=0xFFFFFFF -> out_prod=0xFFFFFFE0000001; out_valid exactly 4 cycles after accept; in_ready low during CALC.
2. op=01, A={14'h3FFF,14'd3}, B={14'd2,14'd5} -> out_prod[27:0]=15, out_prod[55:28]=0x7FFE; latency 2.
3. op=10, A lanes (0..3)=127,1,2,3, B lanes=127,1,2,3 -> lanes 0x3F01, 1, 4, 9; latency 1; no cross-lane leakage.
4. op=00 with out_ready=0 for 5 cycles in DONE and in_valid pulsed with new operands -> out_prod stable, in_ready=0, new request not accepted; accepted after drain.
5. rst_n low at beat 2 of a mode-00 op -> out_valid=0, in_ready=1 after release; next op A=3, B=5 yields 15.
6. op=11, A=B=0x8000000 -> out_prod=0x40000000000000, latency 4, identical to mode 00.
